seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment driver for an N-digit common-anode display. It generates its own scan timebase from the system clock and decodes per-digit hex nibbles, with per-digit decimal point, blanking, leading-zero suppression and PWM brightness. New display values are loaded atomically at frame boundaries, so a display never shows a mix of old and new values. It sits between application logic and the board AN/CA..CG/DP pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16)
CLK_HZ, 100_000_000, input clock frequency
REFRESH_HZ, 1000, digit slot rate (slots per second)
DIM_BITS, 4, brightness resolution; each slot is split into 2**DIM_BITS phases
SUB_DIV, CLK_HZ/(REFRESH_HZ*2**DIM_BITS), clock cycles per phase (localparam, elaboration error if < 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; captures value/dp_in/blank_in
value  in  4*NUM_DIGITS  hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point enable per digit
blank_in  in  NUM_DIGITS  blank whole digit (segments and dp)
lz_suppress  in  1  leading-zero suppression enable (sampled live)
brightness  in  DIM_BITS  on-time: anode on while phase <= brightness (sampled live)
an  out  NUM_DIGITS  anodes, active-low, one-hot-low when on
seg  out  7  cathodes, active-low, seg[0]=a .. seg[6]=g
dp  out  1  decimal point cathode, active-low
frame_tick  out  1  one-cycle pulse at each frame start
update_pending  out  1  a load is waiting for the next frame boundary

Behaviour:
- Reset (async assert): an all ones, seg 7'h7F, dp 1, frame_tick 0, update_pending 0. Prescaler, phase and digit index are 0. Display registers: value 0, dp 0, blank all ones (dark until the first load).
- Prescaler counts 0..SUB_DIV-1; its wrap produces phase_tick.
- On phase_tick, phase increments 0..2**DIM_BITS-1. On phase wrap, the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary = digit index wrapping NUM_DIGITS-1 -> 0. frame_tick pulses the same cycle. The pending set is transferred into the display registers that cycle and update_pending clears.
- Load handling:
  - load asserted -> pending registers capture the inputs; update_pending = 1 next cycle.
  - Load while already pending overwrites the pending set (last load wins).
  - Load in the frame-boundary cycle bypasses pending: the value is transferred directly and update_pending stays 0.
- Hex decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero suppression (lz_suppress=1): scanning from digit NUM_DIGITS-1 downward, digits with nibble 0 show seg 7'h7F until the first nonzero nibble. Digit 0 is never suppressed. A suppressed digit still shows its dp. Blanked digits (blank set) do not end the suppression run.
- Blanked digit: an bit stays high for the whole slot.
- Brightness: the current digit's anode is low only while phase <= brightness. brightness = all ones gives full on-time; 0 gives 1/2**DIM_BITS.
- Output timing: an, seg and dp are registered and update together one cycle after the index/phase change, so there is no cycle with a new anode driving old segments. When an is all ones, seg and dp are 7'h7F and 1.
- Reset mid-frame: outputs go dark immediately and pending loads are discarded.

Decomposition:
- Package seg7_pkg: SEG_BLANK = 7'h7F, the 16-entry hex-to-segment constant table and function hex_to_seg, and the brightness/phase width helper.
- Sub-module seg7_tick_gen: prescaler plus phase/digit counters. Outputs phase, digit index and frame_tick, parametrised by SUB_DIV, DIM_BITS and NUM_DIGITS.

Test Plan:
1. Bench parameters: NUM_DIGITS=4, CLK_HZ=1600, REFRESH_HZ=100, DIM_BITS=2, so SUB_DIV=4, a slot is 16 cycles and a frame is 64 cycles.
2. Reset, no load -> an=4'hF, seg=7'h7F, dp=1 for 200 cycles; frame_tick every 64 cycles.
3. load value=16'h90AF, dp_in=4'b0100, blank_in=0, brightness=3 -> after the next frame_tick, the slots show digit0 seg=0001110 (F), digit1 0001000 (A), digit2 1000000 with dp=0, digit3 0010000 (9). Each an bit is low for all 16 cycles of its slot.
4. value=16'h0007, lz_suppress=1 -> digits 3..1 dark (seg 7'h7F, an low), digit0 seg=1111000. Repeat with lz_suppress=0 -> digits 3..1 show 1000000.
5. brightness=1 -> each an bit is low for exactly 8 of its 16 slot cycles (phases 0,1); brightness=0 -> 4 cycles.
6. Load 16'h1111 mid-frame, then 16'h2222 two cycles later -> update_pending=1 until frame_tick; the display never shows 1111 and shows 2222 from the first slot of the next frame. Load in the frame_tick cycle -> applied immediately, update_pending stays 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
//   SEG_BLANK  : all cathodes off (active-low)
//   HEX_SEG    : hex nibble -> gfedcba cathode pattern, active-low
//   hex_to_seg : table lookup
//   cnt_w      : counter width able to hold 0..n-1 (minimum 1 bit)
//   num_phases : PWM phases per digit slot for a given brightness width
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [n] is the pattern for nibble n; the first element listed is F.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned num_phases(input int unsigned dim_bits);
    return 1 << dim_bits;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Scan timebase: prescaler -> PWM phase -> digit index.
//   clk, rst_n   : clock, async active-low reset
//   o_phase      : PWM phase within the current digit slot
//   o_digit      : digit currently being scanned
//   o_frame_tick : high during the last cycle of a frame; the digit index
//                  wraps to 0 on the clock edge that ends this cycle
module seg7_tick_gen import seg7_pkg::*; #(
  parameter int unsigned SUB_DIV    = 1,
  parameter int unsigned DIM_BITS   = 4,
  parameter int unsigned NUM_DIGITS = 8,
  localparam int unsigned DIG_W     = cnt_w(NUM_DIGITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [DIM_BITS-1:0] o_phase,
  output logic [DIG_W-1:0]    o_digit,
  output logic                o_frame_tick
);

  localparam int unsigned         PRE_W    = cnt_w(SUB_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SUB_DIV - 1);
  localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [DIM_BITS-1:0] PH_LAST  = '1;

  logic [PRE_W-1:0]    r_presc;
  logic [DIM_BITS-1:0] r_phase;
  logic [DIG_W-1:0]    r_digit;
  logic                r_frame_tick;

  logic [PRE_W-1:0]    w_presc_nxt;
  logic [DIM_BITS-1:0] w_phase_nxt;
  logic [DIG_W-1:0]    w_digit_nxt;
  logic                w_phase_tick;
  logic                w_phase_wrap;
  logic                w_last_nxt;

  // Next counter values; frame_tick is registered from the look-ahead so it
  // coincides with the terminal count rather than trailing it.
  always_comb begin
    w_phase_tick = (r_presc == PRE_LAST);
    w_phase_wrap = w_phase_tick && (r_phase == PH_LAST);
    w_presc_nxt  = w_phase_tick ? '0 : r_presc + 1'b1;
    w_phase_nxt  = w_phase_tick ? r_phase + 1'b1 : r_phase;
    w_digit_nxt  = r_digit;
    if (w_phase_wrap) begin
      w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
    end
    w_last_nxt = (w_presc_nxt == PRE_LAST) && (w_phase_nxt == PH_LAST) &&
                 (w_digit_nxt == DIG_LAST);
  end

  // Counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_phase      <= '0;
      r_digit      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_phase      <= w_phase_nxt;
      r_digit      <= w_digit_nxt;
      r_frame_tick <= w_last_nxt;
    end
  end

  assign o_phase      = r_phase;
  assign o_digit      = r_digit;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with hex decode,
// per-digit dp/blank, leading-zero suppression and PWM brightness.
//   clk, rst_n      : clock, async active-low reset
//   load            : strobe capturing value/dp_in/blank_in
//   value           : hex nibbles, digit 0 in bits [3:0] (rightmost)
//   dp_in, blank_in : per-digit decimal point / blanking
//   lz_suppress     : leading-zero suppression (live)
//   brightness      : anode on while phase <= brightness (live)
//   an, seg, dp     : active-low anodes / cathodes / decimal point
//   frame_tick      : one-cycle pulse; new values take effect on its edge
//   update_pending  : a load waits for the next frame boundary
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned DIM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic [DIM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick,
  output logic                    update_pending
);

  import seg7_pkg::*;

  localparam int unsigned SUB_DIV = CLK_HZ / (REFRESH_HZ * num_phases(DIM_BITS));
  localparam int unsigned DIG_W   = cnt_w(NUM_DIGITS);

  if (SUB_DIV < 1) begin : g_bad_sub_div
    $error("seg7_scan_driver: CLK_HZ too low for REFRESH_HZ and DIM_BITS");
  end

  logic [DIM_BITS-1:0]     w_phase;
  logic [DIG_W-1:0]        w_digit;
  logic                    w_frame_tick;

  // Displayed and pending value sets
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_valid;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp_out;

  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [3:0]              w_nib;
  logic                    w_on;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;

  seg7_tick_gen #(
    .SUB_DIV    (SUB_DIV),
    .DIM_BITS   (DIM_BITS),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_tick_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_phase      (w_phase),
    .o_digit      (w_digit),
    .o_frame_tick (w_frame_tick)
  );

  // Leading-zero run from the top digit; blanked digits keep the run going
  always_comb begin : p_lz
    logic run;
    w_lz_mask = '0;
    run       = lz_suppress;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lz_mask[i] = run && (r_value[4*i +: 4] == 4'h0);
      run          = run && (r_blank[i] || (r_value[4*i +: 4] == 4'h0));
    end
  end

  // Next anode/cathode pattern for the current digit and phase
  always_comb begin
    w_nib     = r_value[{w_digit, 2'b00} +: 4];
    w_on      = !r_blank[w_digit] && (w_phase <= brightness);
    w_an_nxt  = '1;
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    if (w_on) begin
      w_an_nxt[w_digit] = 1'b0;
      w_seg_nxt         = w_lz_mask[w_digit] ? SEG_BLANK : hex_to_seg(w_nib);
      w_dp_nxt          = ~r_dp[w_digit];
    end
  end

  // Output registers and frame-atomic value update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp_out     <= 1'b1;
      r_value      <= '0;
      r_dp         <= '0;
      r_blank      <= '1;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_pend_valid <= 1'b0;
    end else begin
      r_an     <= w_an_nxt;
      r_seg    <= w_seg_nxt;
      r_dp_out <= w_dp_nxt;
      if (w_frame_tick) begin
        // A load on the boundary itself goes straight to the display
        if (load) begin
          r_value <= value;
          r_dp    <= dp_in;
          r_blank <= blank_in;
        end else if (r_pend_valid) begin
          r_value <= r_pend_value;
          r_dp    <= r_pend_dp;
          r_blank <= r_pend_blank;
        end
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_value <= value;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign an             = r_an;
  assign seg            = r_seg;
  assign dp             = r_dp_out;
  assign frame_tick     = w_frame_tick;
  assign update_pending = r_pend_valid;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4 cycles/phase,
// 16-cycle slots, 64-cycle frames.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic        update_pending;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .CLK_HZ     (1600),
    .REFRESH_HZ (100),
    .DIM_BITS   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .value          (value),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .lz_suppress    (lz_suppress),
    .brightness     (brightness),
    .an             (an),
    .seg            (seg),
    .dp             (dp),
    .frame_tick     (frame_tick),
    .update_pending (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value    = v;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic wait_ft(input int budget);
    int n = 0;
    while (frame_tick !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("frame_tick_wait", 32'(frame_tick), 32'd1);
  endtask

  // Called one cycle after the frame_tick cycle; checks the 64 output cycles
  // of the frame. segs = {d3,d2,d1,d0} expected patterns when lit.
  task automatic scan_slots(input string tag, input logic [27:0] segs,
                            input logic [3:0] dps, input logic [3:0] blanks,
                            input logic [1:0] b);
    for (int d = 0; d < 4; d++) begin
      int low = 0;
      for (int p = 0; p < 16; p++) begin
        logic [3:0]  e_an;
        logic [11:0] e_out;
        tick();
        e_an = 4'hF;
        if (!blanks[d] && (p / 4 <= int'(b))) begin
          e_an[d] = 1'b0;
          e_out   = {e_an, segs[d*7 +: 7], ~dps[d]};
        end else begin
          e_out   = {4'hF, 7'h7F, 1'b1};
        end
        check($sformatf("%s_d%0d_c%0d", tag, d, p), 32'({an, seg, dp}), 32'(e_out));
        if (an[d] == 1'b0) low++;
      end
      check($sformatf("%s_d%0d_ontime", tag, d), 32'(low),
            blanks[d] ? 32'd0 : 32'((int'(b) + 1) * 4));
    end
  endtask

  task automatic frame(input string tag, input logic [27:0] segs,
                       input logic [3:0] dps, input logic [3:0] blanks,
                       input logic [1:0] b);
    wait_ft(200);
    tick();
    scan_slots(tag, segs, dps, blanks, b);
  endtask

  initial begin
    rst_n       = 1'b0;
    load        = 1'b0;
    value       = '0;
    dp_in       = '0;
    blank_in    = '0;
    lz_suppress = 1'b0;
    brightness  = 2'd3;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_ft", 32'(frame_tick), 32'd0);
    check("rst_pend", 32'(update_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Dark before first load; frame_tick in cycles 63, 127, 191
    for (int k = 1; k <= 200; k++) begin
      tick();
      check($sformatf("idle_out_c%0d", k), 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
      check($sformatf("idle_ft_c%0d", k), 32'(frame_tick), 32'(k % 64 == 63));
    end

    // 90AF, dp on digit 2, full brightness
    drive_load(16'h90AF, 4'b0100, 4'b0000);
    check("load_pend", 32'(update_pending), 32'd1);
    frame("hex", {7'h10, 7'h40, 7'h08, 7'h0E}, 4'b0100, 4'b0000, 2'd3);
    check("hex_pend_clr", 32'(update_pending), 32'd0);

    // Leading-zero suppression on, then off (live)
    lz_suppress = 1'b1;
    drive_load(16'h0007, 4'b0000, 4'b0000);
    frame("lz_on", {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b0000, 4'b0000, 2'd3);
    lz_suppress = 1'b0;
    frame("lz_off", {7'h40, 7'h40, 7'h40, 7'h78}, 4'b0000, 4'b0000, 2'd3);

    // Blanked nonzero digit 2 keeps the run; suppressed digit 1 keeps its dp
    lz_suppress = 1'b1;
    drive_load(16'h0300, 4'b0110, 4'b0100);
    frame("lz_blank", {7'h7F, 7'h30, 7'h7F, 7'h40}, 4'b0110, 4'b0100, 2'd3);

    // Brightness 1 and 0
    lz_suppress = 1'b0;
    brightness  = 2'd1;
    drive_load(16'h90AF, 4'b0100, 4'b0000);
    frame("bright1", {7'h10, 7'h40, 7'h08, 7'h0E}, 4'b0100, 4'b0000, 2'd1);
    brightness = 2'd0;
    frame("bright0", {7'h10, 7'h40, 7'h08, 7'h0E}, 4'b0100, 4'b0000, 2'd0);

    // Two loads mid-frame: last wins, held pending until the boundary
    brightness = 2'd3;
    wait_ft(200);
    repeat (10) tick();
    drive_load(16'h1111, 4'b0000, 4'b0000);
    check("pend_first", 32'(update_pending), 32'd1);
    tick();
    drive_load(16'h2222, 4'b0000, 4'b0000);
    begin
      int n = 0;
      while (frame_tick !== 1'b1 && n < 200) begin
        check("pend_hold", 32'(update_pending), 32'd1);
        check("no_1111", 32'(seg == 7'h79), 32'd0);
        tick();
        n++;
      end
    end
    check("pend_ft", 32'(frame_tick), 32'd1);
    tick();
    scan_slots("last_wins", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000, 4'b0000, 2'd3);
    check("last_wins_pend", 32'(update_pending), 32'd0);

    // Load in the frame_tick cycle bypasses pending
    wait_ft(200);
    drive_load(16'h3333, 4'b0000, 4'b0000);
    check("bypass_pend", 32'(update_pending), 32'd0);
    scan_slots("bypass", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b0000, 4'b0000, 2'd3);
    check("bypass_pend_end", 32'(update_pending), 32'd0);

    // Reset mid-frame: immediate dark, pending load discarded
    drive_load(16'h5555, 4'b0000, 4'b0000);
    check("mid_pend", 32'(update_pending), 32'd1);
    repeat (3) tick();
    check("mid_lit", 32'(an), 32'hE);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
    check("mid_rst_pend", 32'(update_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame("post_rst", {7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b0000, 4'b1111, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
